// File: rtl/data_mem_access_ctrl.sv
// Load/store access controller between the core LSU and a word-wide synchronous SRAM.
// Optional macro DATAMEM_MISALIGN_TRAP_EN: misaligned half/word accesses return an error instead of being force-aligned.
module data_mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [3:0]        i_req_sign_mask,
  output logic              o_resp_valid,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  // state | meaning
  // IDLE  | ready for a request
  // RD    | SRAM read issued
  // CAP   | read data valid; extend for loads, merge for sub-word stores
  // WR    | SRAM full-word write issued
  // RESP  | one-cycle completion pulse
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] CAP  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]        r_state;
  logic              r_we;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [3:0]        r_sign_mask;
  logic [31:0]       r_resp_rdata;
  logic              r_err;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic        w_accept;
  logic [2:0]  w_size;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_legal;
  logic        w_misalign;
  logic [1:0]  w_off;
  logic        w_err;
  logic [4:0]  w_shamt;
  logic [31:0] w_lane;
  logic [31:0] w_load;
  logic [31:0] w_be;
  logic [31:0] w_merged;
  logic        w_sign;
  logic        w_unused_addr;

  assign w_accept  = i_req_valid && (r_state == IDLE);
  assign w_size    = i_req_sign_mask[2:0];
  assign w_is_half = (w_size == 3'b011);
  assign w_is_word = (w_size == 3'b111);
  assign w_legal   = (w_size == 3'b001) || w_is_half || w_is_word;

`ifdef DATAMEM_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_half && i_req_addr[0]) || (w_is_word && (i_req_addr[1:0] != 2'b00));
  assign w_off      = i_req_addr[1:0];
`else
  assign w_misalign = 1'b0;
  assign w_off      = w_is_word ? 2'b00 :
                      w_is_half ? {i_req_addr[1], 1'b0} : i_req_addr[1:0];
`endif

  assign w_err         = !w_legal || w_misalign;
  assign w_unused_addr = ^i_req_addr[ADDR_W-1:MEM_AW+2];

  assign w_shamt = {r_off, 3'b000};
  assign w_lane  = i_mem_rdata >> w_shamt;
  assign w_sign  = r_sign_mask[3];

  always_comb begin
    w_load = i_mem_rdata;
    case (r_sign_mask[2:0])
      3'b001:  w_load = {{24{w_sign & w_lane[7]}}, w_lane[7:0]};
      3'b011:  w_load = {{16{w_sign & w_lane[15]}}, w_lane[15:0]};
      default: w_load = i_mem_rdata;
    endcase
  end

  // Byte-enable mask positioned at the addressed lane(s); only sub-word stores reach the merge.
  assign w_be     = ((r_sign_mask[2:0] == 3'b011) ? 32'h0000_FFFF : 32'h0000_00FF) << w_shamt;
  assign w_merged = (i_mem_rdata & ~w_be) | ((r_wdata << w_shamt) & w_be);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= 32'h0;
      r_sign_mask  <= 4'h0;
      r_resp_rdata <= 32'h0;
      r_err        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we         <= i_req_we;
            r_off        <= w_off;
            r_wdata      <= i_req_wdata;
            r_sign_mask  <= i_req_sign_mask;
            r_resp_rdata <= 32'h0;
            r_err        <= w_err;
            r_mem_addr   <= i_req_addr[MEM_AW+1:2];
            r_mem_wdata  <= i_req_wdata;
            if (w_err)
              r_state <= RESP;
            else if (i_req_we && w_is_word)
              r_state <= WR;
            else
              r_state <= RD;
          end
        end
        RD:   r_state <= CAP;
        CAP: begin
          if (r_we) begin
            r_mem_wdata <= w_merged;
            r_state     <= WR;
          end else begin
            r_resp_rdata <= w_load;
            r_state      <= RESP;
          end
        end
        WR:      r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (r_state == IDLE);
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_err;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_re     = (r_state == RD);
  assign o_mem_we     = (r_state == WR);
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Directed bench for data_mem_access_ctrl with a small behavioural SRAM.
module tb_data_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_sign_mask = 4'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_re   = 0;
  int n_we   = 0;
  int n_both = 0;
  logic [31:0] last_wd = 32'h0;
  logic [9:0]  last_wa = 10'h0;
  logic        preload = 1'b1;
  logic [31:0] mem [0:3];

  always #5 clk = ~clk;

  data_mem_access_ctrl #(.ADDR_W(32), .MEM_AW(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_sign_mask(req_sign_mask), .o_resp_valid(resp_valid),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_mem_addr(mem_addr),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h8899AABB;
      mem[1] <= 32'h11223344;
      mem[2] <= 32'h0;
      mem[3] <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr[1:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[1:0]];
    end
  end

  always @(negedge clk) begin
    if (mem_re) n_re = n_re + 1;
    if (mem_we) begin
      n_we    = n_we + 1;
      last_wd = mem_wdata;
      last_wa = mem_addr;
    end
    if (mem_re && mem_we) n_both = n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] mask, output int lat, output logic [31:0] rd,
                         output logic err, output int dre, output int dwe, output logic rdy);
    int re0, we0;
    re0 = n_re;
    we0 = n_we;
    lat = 0; rd = 32'hX; err = 1'bX; rdy = 1'bX;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_sign_mask = mask;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; rd = resp_rdata; err = resp_err; rdy = req_ready;
        break;
      end
    end
    dre = n_re - re0;
    dwe = n_we - we0;
  endtask

  int lat, dre, dwe;
  logic [31:0] rd;
  logic err, rdy;
  int we0;

  initial begin
    repeat (3) @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    check("rst_re_we", {30'b0, mem_re, mem_we}, 32'd0);
    check("rst_maddr", {22'b0, mem_addr}, 32'h0);

    run_req(1'b0, 32'h3, 32'h0, 4'b1001, lat, rd, err, dre, dwe, rdy);
    check("lb_s_data", rd, 32'hFFFFFF88);
    check("lb_s_lat", lat, 32'd3);
    check("lb_s_err", {31'b0, err}, 32'd0);
    check("lb_s_re", dre, 32'd1);
    check("resp_ready", {31'b0, rdy}, 32'd0);

    run_req(1'b0, 32'h2, 32'h0, 4'b0011, lat, rd, err, dre, dwe, rdy);
    check("lhu_data", rd, 32'h00008899);
    check("lhu_lat", lat, 32'd3);

    run_req(1'b1, 32'h5, 32'h000000EE, 4'b0001, lat, rd, err, dre, dwe, rdy);
    check("sb_re", dre, 32'd1);
    check("sb_we", dwe, 32'd1);
    check("sb_wdata", last_wd, 32'h1122EE44);
    check("sb_waddr", {22'b0, last_wa}, 32'd1);
    check("sb_lat", lat, 32'd4);
    check("sb_rdata", rd, 32'h0);
    check("sb_err", {31'b0, err}, 32'd0);

    run_req(1'b1, 32'h8, 32'hDEADBEEF, 4'b1111, lat, rd, err, dre, dwe, rdy);
    check("sw_re", dre, 32'd0);
    check("sw_we", dwe, 32'd1);
    check("sw_wdata", last_wd, 32'hDEADBEEF);
    check("sw_waddr", {22'b0, last_wa}, 32'd2);
    check("sw_lat", lat, 32'd2);

    run_req(1'b0, 32'h5, 32'h0, 4'b0001, lat, rd, err, dre, dwe, rdy);
    check("lbu_merged", rd, 32'h000000EE);
    run_req(1'b0, 32'h5, 32'h0, 4'b1001, lat, rd, err, dre, dwe, rdy);
    check("lb_merged", rd, 32'hFFFFFFEE);
    run_req(1'b0, 32'h8, 32'h0, 4'b0111, lat, rd, err, dre, dwe, rdy);
    check("lw_stored", rd, 32'hDEADBEEF);
    run_req(1'b0, 32'h3, 32'h0, 4'b1011, lat, rd, err, dre, dwe, rdy);
`ifdef DATAMEM_MISALIGN_TRAP_EN
    check("lh_mis_err", {31'b0, err}, 32'd1);
`else
    check("lh_mis_data", rd, 32'hFFFF8899);
`endif

    run_req(1'b0, 32'h2, 32'h0, 4'b0111, lat, rd, err, dre, dwe, rdy);
`ifdef DATAMEM_MISALIGN_TRAP_EN
    check("lw_mis_err", {31'b0, err}, 32'd1);
    check("lw_mis_lat", lat, 32'd1);
    check("lw_mis_re", dre, 32'd0);
    check("lw_mis_rdata", rd, 32'h0);
`else
    check("lw_mis_data", rd, 32'h8899AABB);
    check("lw_mis_err", {31'b0, err}, 32'd0);
    check("lw_mis_lat", lat, 32'd3);
`endif

    run_req(1'b0, 32'h0, 32'h0, 4'b0000, lat, rd, err, dre, dwe, rdy);
    check("ill_err", {31'b0, err}, 32'd1);
    check("ill_rdata", rd, 32'h0);
    check("ill_lat", lat, 32'd1);
    check("ill_mem", dre + dwe, 32'd0);
    run_req(1'b1, 32'h4, 32'h0, 4'b0101, lat, rd, err, dre, dwe, rdy);
    check("ill_st_err", {31'b0, err}, 32'd1);
    check("ill_st_mem", dre + dwe, 32'd0);

    we0 = n_we;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h5555; req_sign_mask = 4'b0011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_rd", {31'b0, mem_re}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_we", n_we - we0, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_valid", {31'b0, resp_valid}, 32'd0);

    run_req(1'b0, 32'h4, 32'h0, 4'b0111, lat, rd, err, dre, dwe, rdy);
    check("post_abort", rd, 32'h1122EE44);
    check("re_we_excl", n_both, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
